// File: rtl/psr_bank.sv
// Banked program status registers: CPSR plus five per-mode SPSRs, with a small sequencer
// for exception entry/return and direct MSR-style writes.
module psr_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [4:0]  exc_mode,
    input  logic        ret_req,
    input  logic        msr_cpsr_we,
    input  logic        msr_spsr_we,
    input  logic [31:0] msr_data,
    output logic [31:0] cpsr,
    output logic [31:0] spsr_out,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int unsigned NumSpsr = 5;

    localparam logic [4:0] ModeUsr = 5'b10000;
    localparam logic [4:0] ModeFiq = 5'b10001;
    localparam logic [4:0] ModeIrq = 5'b10010;
    localparam logic [4:0] ModeSvc = 5'b10011;
    localparam logic [4:0] ModeAbt = 5'b10111;
    localparam logic [4:0] ModeUnd = 5'b11011;
    localparam logic [4:0] ModeSys = 5'b11111;

    localparam logic [2:0] NoSpsr = 3'd7;
    localparam logic [31:0] CpsrReset = 32'h0000_00D3;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StSwitch,
        StRestore,
        StDone
    } state_e;

    // USR, SYS and undefined encodings share the "no SPSR" index.
    function automatic logic [2:0] spsr_idx(input logic [4:0] mode);
        logic [2:0] idx;
        case (mode)
            ModeFiq: idx = 3'd0;
            ModeSvc: idx = 3'd1;
            ModeAbt: idx = 3'd2;
            ModeIrq: idx = 3'd3;
            ModeUnd: idx = 3'd4;
            ModeUsr, ModeSys: idx = NoSpsr;
            default: idx = NoSpsr;
        endcase
        return idx;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cpsr_q, cpsr_d;
    logic [4:0]  mode_q, mode_d;
    logic        fault_q, fault_d;
    logic [31:0] spsr_q [NumSpsr];

    logic [2:0]  cur_idx;
    logic [31:0] spsr_rd;
    logic        spsr_we;
    logic [2:0]  spsr_widx;
    logic [31:0] spsr_wdata;

    assign cur_idx = spsr_idx(cpsr_q[4:0]);

    always_comb begin
        spsr_rd = '0;
        for (int i = 0; i < NumSpsr; i++) begin
            if (cur_idx == 3'(i)) begin
                spsr_rd = spsr_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cpsr_d     = cpsr_q;
        mode_d     = mode_q;
        fault_d    = 1'b0;
        spsr_we    = 1'b0;
        spsr_widx  = cur_idx;
        spsr_wdata = msr_data;

        unique case (state_q)
            StIdle: begin
                if (exc_req) begin
                    if (spsr_idx(exc_mode) != NoSpsr) begin
                        mode_d  = exc_mode;
                        state_d = StSave;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (ret_req) begin
                    if (cur_idx != NoSpsr) begin
                        state_d = StRestore;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (msr_cpsr_we) begin
                    cpsr_d = msr_data;
                end else if (msr_spsr_we) begin
                    if (cur_idx != NoSpsr) begin
                        spsr_we = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            StSave: begin
                spsr_we    = 1'b1;
                spsr_widx  = spsr_idx(mode_q);
                spsr_wdata = cpsr_q;
                state_d    = StSwitch;
            end
            StSwitch: begin
                // Mask IRQ, mask FIQ only when entering FIQ, force ARM state.
                cpsr_d  = {cpsr_q[31:8], 1'b1, (mode_q == ModeFiq) ? 1'b1 : cpsr_q[6], 1'b0,
                           mode_q};
                state_d = StDone;
            end
            StRestore: begin
                cpsr_d  = spsr_rd;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cpsr_q  <= CpsrReset;
            mode_q  <= ModeSvc;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cpsr_q  <= cpsr_d;
            mode_q  <= mode_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumSpsr; i++) begin
                spsr_q[i] <= '0;
            end
        end else if (spsr_we) begin
            for (int i = 0; i < NumSpsr; i++) begin
                if (spsr_widx == 3'(i)) begin
                    spsr_q[i] <= spsr_wdata;
                end
            end
        end
    end

    assign cpsr     = cpsr_q;
    assign spsr_out = spsr_rd;
    assign busy     = (state_q == StSave) || (state_q == StSwitch) || (state_q == StRestore);
    assign done     = (state_q == StDone);
    assign fault    = fault_q;

endmodule

// File: tb/tb_psr_bank.sv
// Directed bench for psr_bank: a table of request vectors with hand-computed results,
// followed by hand-written reset corner cases.
module tb_psr_bank;

    logic        clk;
    logic        reset;
    logic        exc_req;
    logic [4:0]  exc_mode;
    logic        ret_req;
    logic        msr_cpsr_we;
    logic        msr_spsr_we;
    logic [31:0] msr_data;
    logic [31:0] cpsr;
    logic [31:0] spsr_out;
    logic        busy;
    logic        done;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    psr_bank u_dut (
        .clk         (clk),
        .reset       (reset),
        .exc_req     (exc_req),
        .exc_mode    (exc_mode),
        .ret_req     (ret_req),
        .msr_cpsr_we (msr_cpsr_we),
        .msr_spsr_we (msr_spsr_we),
        .msr_data    (msr_data),
        .cpsr        (cpsr),
        .spsr_out    (spsr_out),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        exc;
        logic [4:0]  mode;
        logic        ret;
        logic        mcw;
        logic        msw;
        logic [31:0] data;
        int          lat;     // cycle of done after acceptance, 0 = single-cycle op
        logic [31:0] e_cpsr;
        logic [31:0] e_spsr;
        logic        e_fault;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic clear_inputs();
        exc_req     = 1'b0;
        exc_mode    = 5'b0;
        ret_req     = 1'b0;
        msr_cpsr_we = 1'b0;
        msr_spsr_we = 1'b0;
        msr_data    = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int busy_cnt;
        @(negedge clk);
        exc_req     = v.exc;
        exc_mode    = v.mode;
        ret_req     = v.ret;
        msr_cpsr_we = v.mcw;
        msr_spsr_we = v.msw;
        msr_data    = v.data;
        n = 0;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
            if (v.lat == 0 || done || n >= 8) break;
        end
        check({v.name, " latency"}, 32'(n), (v.lat == 0) ? 32'd1 : 32'(v.lat));
        check({v.name, " busy cycles"}, 32'(busy_cnt), (v.lat == 0) ? 32'd0 : 32'(v.lat - 1));
        check({v.name, " cpsr"}, cpsr, v.e_cpsr);
        check({v.name, " spsr_out"}, spsr_out, v.e_spsr);
        check({v.name, " fault"}, 32'(fault), 32'(v.e_fault));
        clear_inputs();
        @(posedge clk);
        #1;
        check({v.name, " pulses ended"}, {30'b0, done, fault}, 32'd0);
    endtask

    initial begin
        //           name        exc mode      ret   mcw   msw   data          lat cpsr          spsr          flt
        vecs[0]  = '{"msr_spsr_svc", 0, 5'b00000, 0, 0, 1, 32'hA5A5_0013, 0, 32'h0000_00D3, 32'hA5A5_0013, 0};
        vecs[1]  = '{"msr_usr",      0, 5'b00000, 0, 1, 0, 32'h0000_0010, 0, 32'h0000_0010, 32'h0,         0};
        vecs[2]  = '{"msr_usr_nz",   0, 5'b00000, 0, 1, 0, 32'h6000_0010, 0, 32'h6000_0010, 32'h0,         0};
        vecs[3]  = '{"enter_irq",    1, 5'b10010, 0, 0, 0, 32'h0,         3, 32'h6000_0092, 32'h6000_0010, 0};
        vecs[4]  = '{"ret_irq",      0, 5'b00000, 1, 0, 0, 32'h0,         2, 32'h6000_0010, 32'h0,         0};
        vecs[5]  = '{"exc_beats_ret",1, 5'b10001, 1, 0, 0, 32'h0,         3, 32'h6000_00D1, 32'h6000_0010, 0};
        vecs[6]  = '{"msr_spsr_fiq", 0, 5'b00000, 0, 0, 1, 32'h2000_00D3, 0, 32'h6000_00D1, 32'h2000_00D3, 0};
        vecs[7]  = '{"ret_fiq",      0, 5'b00000, 1, 0, 0, 32'h0,         2, 32'h2000_00D3, 32'hA5A5_0013, 0};
        vecs[8]  = '{"msr_sys",      0, 5'b00000, 0, 1, 0, 32'h0000_001F, 0, 32'h0000_001F, 32'h0,         0};
        vecs[9]  = '{"ret_in_sys",   0, 5'b00000, 1, 0, 0, 32'h0,         0, 32'h0000_001F, 32'h0,         1};
        vecs[10] = '{"exc_mode_0",   1, 5'b00000, 0, 0, 0, 32'h0,         0, 32'h0000_001F, 32'h0,         1};
        vecs[11] = '{"exc_mode_usr", 1, 5'b10000, 0, 0, 0, 32'h0,         0, 32'h0000_001F, 32'h0,         1};
        vecs[12] = '{"msw_in_sys",   0, 5'b00000, 0, 0, 1, 32'h0000_DEAD, 0, 32'h0000_001F, 32'h0,         1};
        vecs[13] = '{"mcw_beats_msw",0, 5'b00000, 0, 1, 1, 32'h0000_001B, 0, 32'h0000_001B, 32'h0,         0};
        vecs[14] = '{"ret_beats_mcw",0, 5'b00000, 1, 1, 0, 32'hFFFF_FFFF, 2, 32'h0000_0000, 32'h0,         0};
        vecs[15] = '{"msr_abt_t",    0, 5'b00000, 0, 1, 0, 32'h0000_0037, 0, 32'h0000_0037, 32'h0,         0};
        vecs[16] = '{"enter_und",    1, 5'b11011, 0, 0, 0, 32'h0,         3, 32'h0000_009B, 32'h0000_0037, 0};
        vecs[17] = '{"enter_svc",    1, 5'b10011, 0, 0, 0, 32'h0,         3, 32'h0000_0093, 32'h0000_009B, 0};

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset cpsr", cpsr, 32'h0000_00D3);
        check("reset spsr_out", spsr_out, 32'h0);
        check("reset outputs", {29'b0, busy, done, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Reset while in SWITCH: entry from SVC to IRQ must leave no trace.
        @(negedge clk);
        exc_req  = 1'b1;
        exc_mode = 5'b10010;
        repeat (2) @(posedge clk);
        #1;
        check("switch busy", 32'(busy), 32'd1);
        check("switch cpsr held", cpsr, 32'h0000_0093);
        reset = 1'b1;
        #1;
        check("async reset cpsr", cpsr, 32'h0000_00D3);
        check("async reset spsr_svc", spsr_out, 32'h0);
        check("async reset outputs", {29'b0, busy, done, fault}, 32'd0);
        clear_inputs();
        @(negedge clk);
        // First request after release is taken at the very next edge.
        reset       = 1'b0;
        msr_cpsr_we = 1'b1;
        msr_data    = 32'h0000_0012;
        @(posedge clk);
        #1;
        check("post-reset msr cpsr", cpsr, 32'h0000_0012);
        check("post-reset spsr_irq", spsr_out, 32'h0);
        clear_inputs();
        @(negedge clk);
        msr_cpsr_we = 1'b1;
        msr_data    = 32'h0000_0011;
        @(posedge clk);
        #1;
        check("post-reset spsr_fiq", spsr_out, 32'h0);
        check("idle after reset", 32'(busy), 32'd0);
        clear_inputs();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psr_bank.md
PSR_BANK -- requirements
Module: psr_bank

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port exc_req, input, 1 bit: exception-entry request, sampled in IDLE.
REQ-004 SHALL have port exc_mode, input, 5 bits: target mode for exception entry.
REQ-005 SHALL have port ret_req, input, 1 bit: exception-return request (CPSR <= SPSR of current mode).
REQ-006 SHALL have port msr_cpsr_we, input, 1 bit: direct CPSR write strobe.
REQ-007 SHALL have port msr_spsr_we, input, 1 bit: SPSR-of-current-mode write strobe.
REQ-008 SHALL have port msr_data, input, 32 bits: write data for both MSR strobes.
REQ-009 SHALL have port cpsr, output, 32 bits: registered current program status register.
REQ-010 SHALL have port spsr_out, output, 32 bits: combinational SPSR of the current mode; 0 when the current mode has no SPSR.
REQ-011 SHALL have port busy, output, 1 bit: high in SAVE, SWITCH and RESTORE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-013 SHALL have port fault, output, 1 bit: registered one-cycle pulse on a rejected request.

Function
REQ-014 Mode encodings SHALL be USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
REQ-015 Five 32-bit SPSRs SHALL be held, indexed FIQ 0, SVC 1, ABT 2, IRQ 3, UND 4; any other mode maps to index 7 (no SPSR).
REQ-016 FSM states SHALL be IDLE, SAVE, SWITCH, RESTORE and DONE.
REQ-017 In IDLE, the priority SHALL be exc_req > ret_req > msr_cpsr_we > msr_spsr_we; only the highest-priority request is acted on.
REQ-018 Accepted exc_req with a banked exc_mode SHALL register exc_mode, go IDLE->SAVE->SWITCH->DONE->IDLE.
REQ-019 Edge leaving SAVE SHALL write SPSR[index(registered mode)] <= cpsr.
REQ-020 Edge leaving SWITCH SHALL load cpsr <= {cpsr[31:8], I=1, F=(mode==FIQ)?1:cpsr[6], T=0, registered mode}.
REQ-021 exc_req with exc_mode USR, SYS or undefined SHALL stay in IDLE, change no state, and pulse fault next cycle.
REQ-022 Accepted ret_req with current mode banked SHALL go IDLE->RESTORE->DONE->IDLE; edge leaving RESTORE loads cpsr <= SPSR[index(cpsr[4:0])].
REQ-023 ret_req in a mode with no SPSR SHALL stay in IDLE, leave cpsr unchanged, and pulse fault.
REQ-024 msr_cpsr_we in IDLE SHALL load cpsr <= msr_data at that edge; the FSM stays IDLE.
REQ-025 msr_spsr_we in IDLE SHALL write SPSR[index(cpsr[4:0])] <= msr_data; with no SPSR the write is dropped and fault pulses.
REQ-026 All requests while not IDLE (including in DONE) SHALL be ignored; the requester holds its request until done.
REQ-027 Latency SHALL be: entry, done in the 3rd cycle after acceptance and cpsr new from that cycle; return, done in the 2nd cycle.
REQ-028 spsr_out SHALL track cpsr[4:0] combinationally, including in the same cycle a mode change becomes visible.

Reset
REQ-029 Reset SHALL asynchronously force cpsr = 32'h000000D3 (SVC, I=1, F=1, T=0), all SPSRs = 0, state IDLE, busy = 0, done = 0, fault = 0.
REQ-030 Reset mid-operation SHALL abort the sequence; a SAVE or RESTORE not yet completed leaves no effect.
REQ-031 The first request SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-032 Sequence SHALL be: after reset, msr_cpsr_we with 0x00000010 -> cpsr = 0x10 (USR), spsr_out = 0.
REQ-033 Sequence SHALL be: from USR cpsr 0x60000010, exc_req with exc_mode 10010 -> SPSR[3] = 0x60000010, cpsr = 0x60000092, done at acceptance+3, busy for 2 cycles.
REQ-034 Sequence SHALL be: in IRQ, ret_req -> cpsr = 0x60000010 at acceptance+2, done pulses once, spsr_out = 0 afterwards.
REQ-035 Sequence SHALL be: exc_req with exc_mode 10001 and ret_req asserted together in IDLE -> entry taken, F = 1, SPSR[0] written, ret_req ignored.
REQ-036 Sequence SHALL be: in SYS, ret_req, then exc_req with exc_mode 00000 -> fault pulses each time, cpsr unchanged, busy stays 0.
REQ-037 Sequence SHALL be: reset asserted in SWITCH -> immediate cpsr = 0xD3, all SPSRs = 0, state IDLE.
